mem_stage: RTL and testbench

Parametrised RISC-V memory-access stage sitting between the EX/MEM and MEM/WB pipeline registers. It accepts one load/store/pass-through request per handshake, performs byte/half/word access with byte enables and sign/zero extension on an internal word-addressed data RAM, and presents a registered MEM/WB result. It has a configurable access latency with ready back-pressure, and flags misaligned, out-of-range and illegal accesses.

---
 rtl/mem_stage_pkg.sv | 29 ++
 rtl/mem_stage_lsu_align.sv | 53 +++++
 rtl/mem_stage.sv | 171 +++++++++++++++++
 tb/tb_mem_stage.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: funct3 access codes,
// FSM state encoding and the funct3 legality helper.
package mem_stage_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    function automatic logic funct3_illegal(input logic [2:0] funct3, input logic is_store);
        logic bad;
        if (is_store) begin
            bad = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
        end else begin
            bad = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W ||
                    funct3 == F3_BU || funct3 == F3_HU);
        end
        return bad;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane steering for loads and stores: byte enables, store-data
// replication, load extraction with sign/zero extension, and access checks.
module lsu_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_lane,
    input  logic            i_is_store,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_rdata_word,
    output logic [3:0]      o_byte_en,
    output logic [XLEN-1:0] o_wdata_lane,
    output logic [XLEN-1:0] o_load_ext,
    output logic            o_misaligned,
    output logic            o_illegal
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = i_rdata_word[{i_lane, 3'b000} +: 8];
    assign half_sel = i_lane[1] ? i_rdata_word[31:16] : i_rdata_word[15:0];

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        o_byte_en    = 4'b0000;
        o_wdata_lane = i_wdata;
        o_load_ext   = '0;
        o_misaligned = 1'b0;
        case (i_funct3[1:0])
            2'b00: begin
                o_byte_en    = 4'b0001 << i_lane;
                o_wdata_lane = {4{i_wdata[7:0]}};
                o_load_ext   = i_funct3[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            2'b01: begin
                o_byte_en    = i_lane[1] ? 4'b1100 : 4'b0011;
                o_wdata_lane = {2{i_wdata[15:0]}};
                o_load_ext   = i_funct3[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
                o_misaligned = i_lane[0];
            end
            2'b10: begin
                o_byte_en    = 4'b1111;
                o_load_ext   = i_rdata_word;
                o_misaligned = |i_lane;
            end
            default: ;
        endcase
    end

    assign o_illegal = funct3_illegal(i_funct3, i_is_store);

endmodule

// File: rtl/mem_stage.sv
// RISC-V memory-access stage: accepts one request per handshake, applies it
// to a word-addressed data RAM after LATENCY cycles and registers the result.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int WORD_SIZE   = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 1,
    parameter int REG_WR_SIZE = 5
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [WORD_SIZE-1:0]   i_addr,
    input  logic [WORD_SIZE-1:0]   i_wdata,
    input  logic [2:0]             i_funct3,
    input  logic                   i_mem_read,
    input  logic                   i_mem_write,
    input  logic [REG_WR_SIZE-1:0] i_rd,
    input  logic                   i_reg_write,
    input  logic [WORD_SIZE-1:0]   i_pc,
    output logic                   o_wb_valid,
    output logic [WORD_SIZE-1:0]   o_wb_data,
    output logic [REG_WR_SIZE-1:0] o_wb_rd,
    output logic                   o_wb_reg_write,
    output logic [WORD_SIZE-1:0]   o_mem_pc,
    output logic                   o_fault
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef struct packed {
        logic [WORD_SIZE-1:0]   addr;
        logic [WORD_SIZE-1:0]   wdata;
        logic [WORD_SIZE-1:0]   pc;
        logic [2:0]             funct3;
        logic                   mem_read;
        logic                   mem_write;
        logic [REG_WR_SIZE-1:0] rd;
        logic                   reg_write;
    } req_t;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    req_t                 req_q;
    logic [WORD_SIZE-1:0] mem_q [DEPTH_WORDS];

    logic                 accept, commit;
    logic [IDX_W-1:0]     word_idx;
    logic [WORD_SIZE-1:0] rdata_word, wdata_lane, load_ext, wb_data_d;
    logic [3:0]           byte_en;
    logic                 misaligned, illegal, out_of_range, is_access, fault_d, ram_we;

    assign o_ready = (state_q == ST_IDLE) || (state_q == ST_BUSY && cnt_q == '0);
    assign accept  = i_valid && o_ready;
    assign commit  = (state_q == ST_BUSY) && (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (accept) begin
                    cnt_d = CNT_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                req_q.addr      <= i_addr;
                req_q.wdata     <= i_wdata;
                req_q.pc        <= i_pc;
                req_q.funct3    <= i_funct3;
                req_q.mem_read  <= i_mem_read;
                req_q.mem_write <= i_mem_write;
                req_q.rd        <= i_rd;
                req_q.reg_write <= i_reg_write;
            end
        end
    end

    // Reading the RAM combinationally at commit lets a load see the store committed one slot earlier.
    assign word_idx   = req_q.addr[IDX_W+1:2];
    assign rdata_word = mem_q[word_idx];

    lsu_align u_lsu_align (
        .i_funct3     (req_q.funct3),
        .i_lane       (req_q.addr[1:0]),
        .i_is_store   (req_q.mem_write),
        .i_wdata      (req_q.wdata),
        .i_rdata_word (rdata_word),
        .o_byte_en    (byte_en),
        .o_wdata_lane (wdata_lane),
        .o_load_ext   (load_ext),
        .o_misaligned (misaligned),
        .o_illegal    (illegal)
    );

    assign is_access    = req_q.mem_read || req_q.mem_write;
    assign out_of_range = |req_q.addr[WORD_SIZE-1:IDX_W+2];
    assign fault_d      = (req_q.mem_read && req_q.mem_write) ||
                          (is_access && (misaligned || illegal || out_of_range));
    assign ram_we       = commit && req_q.mem_write && !fault_d;

    always_comb begin
        wb_data_d = '0;
        if (!fault_d) begin
            if (req_q.mem_read) begin
                wb_data_d = load_ext;
            end else if (!req_q.mem_write) begin
                wb_data_d = req_q.addr;
            end
        end
    end

    // NOTE: the RAM array has no reset; its contents are undefined until written.
    always_ff @(posedge i_clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wb_valid     <= 1'b0;
            o_wb_data      <= '0;
            o_wb_rd        <= '0;
            o_wb_reg_write <= 1'b0;
            o_mem_pc       <= '0;
            o_fault        <= 1'b0;
        end else begin
            o_wb_valid <= commit;
            if (commit) begin
                o_wb_data      <= wb_data_d;
                o_wb_rd        <= req_q.rd;
                o_wb_reg_write <= req_q.reg_write && !fault_d;
                o_mem_pc       <= req_q.pc;
                o_fault        <= fault_d;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a LATENCY=1 and a LATENCY=3 instance share the
// request fields but have their own valid and reset.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1_n, rst3_n, valid1, valid3;
    logic [31:0] addr, wdata, pc;
    logic [2:0]  f3;
    logic        mr, mw, rw;
    logic [4:0]  rd;

    logic        ready1, wb_valid1, wb_rw1, fault1;
    logic [31:0] wb_data1, mem_pc1;
    logic [4:0]  wb_rd1;
    logic        ready3, wb_valid3, wb_rw3, fault3;
    logic [31:0] wb_data3, mem_pc3;
    logic [4:0]  wb_rd3;

    int n_total = 0;
    int n_pass  = 0;

    mem_stage #(.WORD_SIZE(32), .DEPTH_WORDS(256), .LATENCY(1), .REG_WR_SIZE(5)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst1_n), .i_valid(valid1), .o_ready(ready1),
        .i_addr(addr), .i_wdata(wdata), .i_funct3(f3), .i_mem_read(mr), .i_mem_write(mw),
        .i_rd(rd), .i_reg_write(rw), .i_pc(pc),
        .o_wb_valid(wb_valid1), .o_wb_data(wb_data1), .o_wb_rd(wb_rd1),
        .o_wb_reg_write(wb_rw1), .o_mem_pc(mem_pc1), .o_fault(fault1)
    );

    mem_stage #(.WORD_SIZE(32), .DEPTH_WORDS(256), .LATENCY(3), .REG_WR_SIZE(5)) u_dut3 (
        .i_clk(clk), .i_rst_n(rst3_n), .i_valid(valid3), .o_ready(ready3),
        .i_addr(addr), .i_wdata(wdata), .i_funct3(f3), .i_mem_read(mr), .i_mem_write(mw),
        .i_rd(rd), .i_reg_write(rw), .i_pc(pc),
        .o_wb_valid(wb_valid3), .o_wb_data(wb_data3), .o_wb_rd(wb_rd3),
        .o_wb_reg_write(wb_rw3), .o_mem_pc(mem_pc3), .o_fault(fault3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic set_req(input logic r, input logic w, input logic [2:0] f,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [4:0] dst, input logic wen, input logic [31:0] p);
        mr = r; mw = w; f3 = f; addr = a; wdata = d; rd = dst; rw = wen; pc = p;
    endtask

    // Issue one request to the chosen instance and wait (bounded) for its result strobe.
    task automatic op(input bit d3, input string tag, input logic r, input logic w,
                      input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                      input logic [4:0] dst, input logic wen, input logic [31:0] p);
        logic seen;
        set_req(r, w, f, a, d, dst, wen, p);
        if (d3) valid3 = 1'b1; else valid1 = 1'b1;
        @(posedge clk); #1;
        valid1 = 1'b0;
        valid3 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(posedge clk); #1;
            seen = d3 ? wb_valid3 : wb_valid1;
        end
        check({tag, " strobe"}, 32'(seen), 32'd1);
    endtask

    initial begin
        valid1 = 1'b0; valid3 = 1'b0;
        set_req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        rst1_n = 1'b0; rst3_n = 1'b0;
        #12;
        rst1_n = 1'b1; rst3_n = 1'b1;
        @(posedge clk); #1;

        check("rst ready1", 32'(ready1), 32'd1);
        check("rst valid1", 32'(wb_valid1), 32'd0);
        check("rst data1", wb_data1, 32'h0);
        check("rst rd1", 32'(wb_rd1), 32'd0);
        check("rst rw1", 32'(wb_rw1), 32'd0);
        check("rst pc1", mem_pc1, 32'h0);
        check("rst fault1", 32'(fault1), 32'd0);
        check("rst ready3", 32'(ready3), 32'd1);
        check("rst valid3", 32'(wb_valid3), 32'd0);

        // SW then LW on consecutive cycles, LATENCY=1
        set_req(1'b0, 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 32'h100);
        valid1 = 1'b1;
        @(posedge clk); #1;
        check("b2b ready a", 32'(ready1), 32'd1);
        set_req(1'b1, 1'b0, F3_W, 32'h10, 32'h0, 5'd5, 1'b1, 32'h104);
        @(posedge clk); #1;
        check("b2b sw valid", 32'(wb_valid1), 32'd1);
        check("b2b sw data", wb_data1, 32'h0);
        check("b2b sw pc", mem_pc1, 32'h100);
        check("b2b ready b", 32'(ready1), 32'd1);
        valid1 = 1'b0;
        @(posedge clk); #1;
        check("b2b lw valid", 32'(wb_valid1), 32'd1);
        check("b2b lw data", wb_data1, 32'hDEADBEEF);
        check("b2b lw rd", 32'(wb_rd1), 32'd5);
        check("b2b lw pc", mem_pc1, 32'h104);
        check("b2b lw rw", 32'(wb_rw1), 32'd1);
        @(posedge clk); #1;
        check("hold valid", 32'(wb_valid1), 32'd0);
        check("hold data", wb_data1, 32'hDEADBEEF);

        // Byte and halfword lanes
        op(0, "sw0", 1'b0, 1'b1, F3_W, 32'h10, 32'h0, 5'd0, 1'b0, 32'h110);
        op(0, "sb", 1'b0, 1'b1, F3_B, 32'h13, 32'h12345680, 5'd0, 1'b0, 32'h114);
        check("sb fault", 32'(fault1), 32'd0);
        op(0, "lw sb", 1'b1, 1'b0, F3_W, 32'h10, 32'h0, 5'd1, 1'b1, 32'h118);
        check("lw after sb", wb_data1, 32'h80000000);
        op(0, "lb", 1'b1, 1'b0, F3_B, 32'h13, 32'h0, 5'd2, 1'b1, 32'h11C);
        check("lb data", wb_data1, 32'hFFFFFF80);
        op(0, "lbu", 1'b1, 1'b0, F3_BU, 32'h13, 32'h0, 5'd2, 1'b1, 32'h120);
        check("lbu data", wb_data1, 32'h00000080);
        op(0, "lh", 1'b1, 1'b0, F3_H, 32'h12, 32'h0, 5'd2, 1'b1, 32'h124);
        check("lh data", wb_data1, 32'hFFFF8000);
        op(0, "lhu", 1'b1, 1'b0, F3_HU, 32'h12, 32'h0, 5'd2, 1'b1, 32'h128);
        check("lhu data", wb_data1, 32'h00008000);
        op(0, "sh", 1'b0, 1'b1, F3_H, 32'h10, 32'hCAFEBEEF, 5'd0, 1'b0, 32'h12C);
        op(0, "lw sh", 1'b1, 1'b0, F3_W, 32'h10, 32'h0, 5'd3, 1'b1, 32'h130);
        check("lw after sh", wb_data1, 32'h8000BEEF);

        // Misaligned accesses
        op(0, "lh mis", 1'b1, 1'b0, F3_H, 32'h21, 32'h0, 5'd3, 1'b1, 32'h200);
        check("lh mis fault", 32'(fault1), 32'd1);
        check("lh mis rw", 32'(wb_rw1), 32'd0);
        check("lh mis data", wb_data1, 32'h0);
        op(0, "sw20", 1'b0, 1'b1, F3_W, 32'h20, 32'h11223344, 5'd0, 1'b0, 32'h204);
        check("sw20 fault", 32'(fault1), 32'd0);
        op(0, "sw mis", 1'b0, 1'b1, F3_W, 32'h22, 32'hAAAAAAAA, 5'd0, 1'b0, 32'h208);
        check("sw mis fault", 32'(fault1), 32'd1);
        op(0, "lw20", 1'b1, 1'b0, F3_W, 32'h20, 32'h0, 5'd4, 1'b1, 32'h20C);
        check("lw20 unchanged", wb_data1, 32'h11223344);

        // Range, pass-through and illegal encodings
        op(0, "lw oor", 1'b1, 1'b0, F3_W, 32'h400, 32'h0, 5'd4, 1'b1, 32'h210);
        check("lw oor fault", 32'(fault1), 32'd1);
        op(0, "lw top", 1'b1, 1'b0, F3_W, 32'h3FC, 32'h0, 5'd4, 1'b1, 32'h214);
        check("lw top fault", 32'(fault1), 32'd0);
        op(0, "pass", 1'b0, 1'b0, F3_B, 32'h1234, 32'h0, 5'd4, 1'b1, 32'h218);
        check("pass data", wb_data1, 32'h1234);
        check("pass fault", 32'(fault1), 32'd0);
        check("pass rw", 32'(wb_rw1), 32'd1);
        check("pass rd", 32'(wb_rd1), 32'd4);
        op(0, "ld f3 011", 1'b1, 1'b0, 3'b011, 32'h20, 32'h0, 5'd6, 1'b1, 32'h21C);
        check("ld f3 011 fault", 32'(fault1), 32'd1);
        op(0, "st f3 100", 1'b0, 1'b1, 3'b100, 32'h20, 32'h55555555, 5'd0, 1'b0, 32'h220);
        check("st f3 100 fault", 32'(fault1), 32'd1);
        op(0, "rd+wr", 1'b1, 1'b1, F3_W, 32'h20, 32'h66666666, 5'd6, 1'b1, 32'h224);
        check("rd+wr fault", 32'(fault1), 32'd1);
        check("rd+wr rw", 32'(wb_rw1), 32'd0);
        op(0, "lw20 b", 1'b1, 1'b0, F3_W, 32'h20, 32'h0, 5'd6, 1'b1, 32'h228);
        check("lw20 after faults", wb_data1, 32'h11223344);

        // LATENCY=3: timing and back-pressure with a held second request
        op(1, "l3 sw", 1'b0, 1'b1, F3_W, 32'h40, 32'h55667788, 5'd0, 1'b0, 32'h1FC);
        set_req(1'b1, 1'b0, F3_W, 32'h40, 32'h0, 5'd7, 1'b1, 32'h200);
        valid3 = 1'b1;
        @(posedge clk); #1;
        check("l3 ready e0", 32'(ready3), 32'd0);
        set_req(1'b0, 1'b0, F3_W, 32'hCAFE, 32'h0, 5'd9, 1'b1, 32'h204);
        @(posedge clk); #1;
        check("l3 ready e1", 32'(ready3), 32'd0);
        check("l3 valid e1", 32'(wb_valid3), 32'd0);
        @(posedge clk); #1;
        check("l3 ready e2", 32'(ready3), 32'd1);
        check("l3 valid e2", 32'(wb_valid3), 32'd0);
        @(posedge clk); #1;
        valid3 = 1'b0;
        check("l3 valid e3", 32'(wb_valid3), 32'd1);
        check("l3 data e3", wb_data3, 32'h55667788);
        check("l3 rd e3", 32'(wb_rd3), 32'd7);
        check("l3 second accepted", 32'(ready3), 32'd0);
        @(posedge clk); #1;
        check("l3 valid e4", 32'(wb_valid3), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("l3 valid e6", 32'(wb_valid3), 32'd1);
        check("l3 data e6", wb_data3, 32'hCAFE);
        check("l3 pc e6", mem_pc3, 32'h204);

        // Reset one cycle after a store is accepted drops the store
        set_req(1'b0, 1'b1, F3_W, 32'h40, 32'h99999999, 5'd0, 1'b0, 32'h300);
        valid3 = 1'b1;
        @(posedge clk); #1;
        valid3 = 1'b0;
        @(posedge clk); #1;
        rst3_n = 1'b0;
        #1;
        check("mid rst valid", 32'(wb_valid3), 32'd0);
        check("mid rst data", wb_data3, 32'h0);
        check("mid rst rd", 32'(wb_rd3), 32'd0);
        check("mid rst pc", mem_pc3, 32'h0);
        @(posedge clk);
        @(posedge clk); #3;
        rst3_n = 1'b1;
        #1;
        check("mid rst ready", 32'(ready3), 32'd1);
        op(1, "l3 lw old", 1'b1, 1'b0, F3_W, 32'h40, 32'h0, 5'd8, 1'b1, 32'h304);
        check("l3 old data", wb_data3, 32'h55667788);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
